// File: rtl/srl_fifo16x32_if.sv
// Producer/consumer bundle for the 16x32 shift-register FIFO.
// The FIFO takes the slave modport; the environment driving it takes master.
interface srl_fifo16x32_if;
   logic [31:0] d;
   logic        wr;
   logic        full;
   logic [31:0] y;
   logic        vld;
   logic        rd;
   logic [4:0]  cnt;
   logic        ovf;

   modport master (output d, wr, rd, input full, y, vld, cnt, ovf);
   modport slave  (input d, wr, rd, output full, y, vld, cnt, ovf);
endinterface

// File: rtl/srl_fifo16x32.sv
// 16-deep x 32-bit shift-register FIFO with a registered output stage.
// The newest word enters stage 0; the head is read from stage sc-1.
module srl_fifo16x32 (
   input  logic             clk,
   input  logic             rst,
   srl_fifo16x32_if.slave   bus
);

   logic [15:0][31:0] mem_q, mem_d;
   logic [4:0]        sc_q, sc_d;
   logic              vld_q, vld_d;
   logic [31:0]       y_q, y_d;
   logic              ovf_q, ovf_d;

   logic              full;
   logic              accept_w;
   logic              load;
   logic [3:0]        rd_addr;
   logic [31:0]       head;

   assign full     = (sc_q == 5'd16);
   assign accept_w = bus.wr & ~full;
   assign load     = (sc_q != 5'd0) & (~vld_q | bus.rd);
   // 4-bit wrap makes sc=16 address stage 15; sc=0 never loads.
   assign rd_addr  = sc_q[3:0] - 4'd1;
   assign head     = mem_q[rd_addr];

   always_comb begin
      mem_d = mem_q;
      if (accept_w)
         mem_d = {mem_q[14:0], bus.d};
   end

   always_comb begin
      sc_d  = sc_q + {4'd0, accept_w} - {4'd0, load};
      vld_d = load | (vld_q & ~bus.rd);
      y_d   = y_q;
      if (load)
         y_d = head;
      ovf_d = ovf_q | (bus.wr & full);
   end

   // Storage is deliberately left unreset; stale stages are never addressed.
   always_ff @(posedge clk)
      mem_q <= mem_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sc_q  <= 5'd0;
         vld_q <= 1'b0;
         y_q   <= 32'h0;
         ovf_q <= 1'b0;
      end else begin
         sc_q  <= sc_d;
         vld_q <= vld_d;
         y_q   <= y_d;
         ovf_q <= ovf_d;
      end
   end

   assign bus.full = full;
   assign bus.y    = y_q;
   assign bus.vld  = vld_q;
   assign bus.cnt  = sc_q + {4'd0, vld_q};
   assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_srl_fifo16x32.sv
// Directed and random stimulus for srl_fifo16x32 against a queue scoreboard.
module tb_srl_fifo16x32;
   logic clk = 1'b0;
   logic rst = 1'b1;
   srl_fifo16x32_if bus();

   srl_fifo16x32 dut (.clk(clk), .rst(rst), .bus(bus.slave));

   always #5 clk = ~clk;

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;

   logic [31:0] q[$];
   int          m_sc;
   logic        m_vld;
   logic        m_ovf;
   logic [31:0] m_y;
   logic        saw_full;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: got %h, want %h", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      q.delete();
      m_sc  = 0;
      m_vld = 1'b0;
      m_ovf = 1'b0;
      m_y   = 32'h0;
   endtask

   task automatic check_state(input string tag);
      chk({tag, ".vld"},  {31'd0, bus.vld},  {31'd0, m_vld});
      chk({tag, ".cnt"},  {27'd0, bus.cnt},  q.size());
      chk({tag, ".full"}, {31'd0, bus.full}, {31'd0, (m_sc == 16)});
      chk({tag, ".ovf"},  {31'd0, bus.ovf},  {31'd0, m_ovf});
      chk({tag, ".y"},    bus.y,             m_y);
   endtask

   // One clock: drive inputs, advance the scoreboard, then sample 1ns after the edge.
   task automatic cycle(input string tag, input logic w, input logic [31:0] dat, input logic r);
      logic acc, ld;
      bus.wr = w;
      bus.d  = dat;
      bus.rd = r;
      acc = w && (m_sc != 16);
      ld  = (m_sc != 0) && (!m_vld || r);
      if (w && m_sc == 16) m_ovf = 1'b1;
      if (m_vld && r) void'(q.pop_front());
      if (acc) q.push_back(dat);
      m_sc  = m_sc + int'(acc) - int'(ld);
      m_vld = ld || (m_vld && !r);
      if (m_vld) m_y = q[0];
      @(posedge clk);
      #1;
      if (bus.full) saw_full = 1'b1;
      check_state(tag);
   endtask

   task automatic async_reset(input string tag);
      #2 rst = 1'b1;
      #1;
      model_clear();
      check_state({tag, ".inrst"});
      #1 rst = 1'b0;
   endtask

   initial begin
      bus.wr = 1'b0;
      bus.rd = 1'b0;
      bus.d  = 32'h0;
      model_clear();
      saw_full = 1'b0;
      #3;
      check_state("por");
      @(posedge clk);
      #1;
      check_state("por_clk");
      rst = 1'b0;
      #1;

      // Single word: valid two edges after the write.
      cycle("single.w", 1'b1, 32'hA5A5_0001, 1'b0);
      chk("single.lat", {31'd0, bus.vld}, 32'd0);
      cycle("single.h", 1'b0, 32'h0, 1'b0);
      chk("single.y", bus.y, 32'hA5A5_0001);
      chk("single.cnt", {27'd0, bus.cnt}, 32'd1);
      cycle("single.rd", 1'b0, 32'h0, 1'b1);

      // Fill past capacity, then drain.
      for (int i = 1; i <= 20; i++) cycle("fill.w", 1'b1, i, 1'b0);
      chk("fill.cnt", {27'd0, bus.cnt}, 32'd17);
      chk("fill.full", {31'd0, bus.full}, 32'd1);
      chk("fill.ovf", {31'd0, bus.ovf}, 32'd1);
      for (int i = 1; i <= 17; i++) begin
         chk("fill.order", bus.y, i);
         cycle("fill.rd", 1'b0, 32'h0, 1'b1);
      end
      chk("fill.empty", {27'd0, bus.cnt}, 32'd0);

      // Streaming: one word per cycle once primed.
      async_reset("rst_a");
      saw_full = 1'b0;
      for (int i = 0; i < 20; i++) begin
         cycle("stream", 1'b1, i, 1'b1);
         if (i >= 1) chk("stream.y", bus.y, i - 1);
         if (i >= 1) chk("stream.sc", {27'd0, bus.cnt} - {31'd0, bus.vld}, 32'd1);
      end
      chk("stream.nofull", {31'd0, saw_full}, 32'd0);
      for (int i = 0; i < 3; i++) cycle("stream.drain", 1'b0, 32'h0, 1'b1);

      // Backpressure with alternating accepts.
      for (int i = 1; i <= 4; i++) cycle("bp.w", 1'b1, i, 1'b0);
      for (int k = 0; k < 10; k++) cycle("bp.rd", 1'b0, 32'h0, (k % 2) == 0);
      chk("bp.empty", {27'd0, bus.cnt}, 32'd0);

      // Simultaneous write and pop while storage is full.
      async_reset("rst_b");
      for (int i = 1; i <= 17; i++) cycle("sf.w", 1'b1, 32'h100 + i, 1'b0);
      chk("sf.pre_ovf", {31'd0, bus.ovf}, 32'd0);
      cycle("sf.both", 1'b1, 32'hDEAD_DEAD, 1'b1);
      chk("sf.ovf", {31'd0, bus.ovf}, 32'd1);
      chk("sf.cnt", {27'd0, bus.cnt}, 32'd16);
      chk("sf.y", bus.y, 32'h102);
      for (int i = 0; i < 17; i++) cycle("sf.drain", 1'b0, 32'h0, 1'b1);

      // Mid-operation reset discards held words.
      async_reset("rst_c");
      for (int i = 1; i <= 5; i++) cycle("mr.w", 1'b1, 32'h50 + i, 1'b0);
      chk("mr.cnt5", {27'd0, bus.cnt}, 32'd5);
      async_reset("rst_d");
      cycle("mr.idle", 1'b0, 32'h0, 1'b1);
      cycle("mr.w", 1'b1, 32'h0000_BEEF, 1'b0);
      chk("mr.lat", {31'd0, bus.vld}, 32'd0);
      cycle("mr.h", 1'b0, 32'h0, 1'b0);
      chk("mr.y", bus.y, 32'h0000_BEEF);

      // Random interleaving.
      for (int i = 0; i < 400; i++)
         cycle("rand", 1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 2) != 0));
      for (int i = 0; i < 20; i++) cycle("rand.drain", 1'b0, 32'h0, 1'b1);
      chk("rand.empty", {27'd0, bus.cnt}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/srl_fifo16x32.md
SRL_FIFO16X32 -- requirements
Module: srl_fifo16x32

Interface
REQ-001 The block SHALL have these parameters: none; depth 16 and width 32 are fixed.
REQ-002 The block SHALL have these ports:
- clk  input  1  clock; all state changes on its rising edge.
- rst  input  1  reset; asynchronous, active-high.
- d  input  32  write data.
- wr  input  1  write strobe; a word is offered in any cycle where wr=1.
- full  output  1  1 when storage holds 16 words.
- y  output  32  registered read data; head of FIFO.
- vld  output  1  1 when y holds a valid word.
- rd  input  1  consumer accept; the word on y is consumed in any cycle where vld=1 and rd=1.
- cnt  output  5  total words held: storage plus output register, 0..17.
- ovf  output  1  sticky overflow flag.
REQ-003 The block SHALL use exactly one clock, clk, and reset rst SHALL be asynchronous and active-high.

Function
REQ-004 Storage SHALL be a 16-stage x 32-bit shift array, with read access by 4-bit address.
- Each accepted write shifts every stage up by one and loads d into stage 0.
- The storage count sc is 0..16, and the oldest word sits at stage sc-1.
REQ-005 A write SHALL be accepted when wr=1 and full=0; accept_w = wr & ~full.
REQ-006 full SHALL equal (sc==16) and SHALL be combinational from the registered sc.
REQ-007 When wr=1 and full=1, the write SHALL be ignored and ovf SHALL be set to 1.
- ovf stays 1 until reset.
- A write while full is not accepted, even if a pop occurs in the same cycle.
REQ-008 The output register SHALL load when (sc!=0) & (~vld | rd).
- load = (sc!=0) & (~vld | rd).
- On load, y takes storage stage sc-1, read before the same-edge shift, and vld becomes 1.
REQ-009 When vld=1, rd=1 and sc=0, vld SHALL go to 0 and y SHALL hold its last value.
REQ-010 rd with vld=0 SHALL have no effect.
REQ-011 sc SHALL update as sc_next = sc + accept_w - load.
- When a write and a load occur in the same cycle, sc is unchanged and the data order is preserved.
REQ-012 vld SHALL update as vld_next = load | (vld & ~rd).
REQ-013 cnt SHALL equal sc + vld.
REQ-014 Latency SHALL be 2 cycles from a write to an empty FIFO until that word is valid.
- wr is sampled at edge N, giving sc=1.
- load occurs at edge N+1, so vld=1 after edge N+1.
REQ-015 Once vld is high, the block SHALL deliver 1 word/cycle when rd is held high and sc>0.
REQ-016 y SHALL change only on load.
- y holds its value while vld=1 and rd=0, regardless of writes.
REQ-017 Words SHALL leave in strict write order, with no duplication or loss for any interleaving of wr and rd.
REQ-018 Maximum occupancy SHALL be 17 words: 16 in storage plus 1 in the output register.
REQ-019 Storage stage contents SHALL NOT be reset; unread stages never reach y.

Reset
REQ-020 While rst=1, the block SHALL hold sc=0, vld=0, y=32'h0 and ovf=0, giving full=0 and cnt=0, independent of clk.
REQ-021 Asserting rst mid-operation SHALL discard all held words.
- The first vld after rst deasserts comes only from a write accepted after deassertion.
REQ-022 The first clk edge with rst=0 SHALL obey REQ-005 through REQ-012 normally.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- Single word: from reset, write d=32'hA5A5_0001 at edge N, rd=0 -> vld=1 and y=32'hA5A5_0001 after edge N+1; cnt=1.
- Fill to full: write 1..20 with rd=0 -> full=1 after 17 accepted writes, cnt=17, ovf=1; then rd=1 continuous -> y=1..17 in order on consecutive cycles, then vld=0 and cnt=0.
- Streaming: wr=1 and rd=1 every cycle with d=0,1,2,... -> after 2-cycle fill, y increments by 1 each cycle, sc stays 1, full never asserts.
- Backpressure: 4 words in, rd toggling 1,0,1,0 -> y holds during rd=0 cycles and pops on rd=1; order 1,2,3,4 with no repeats.
- Simultaneous at full: sc=16, vld=1, wr=1, rd=1 -> write rejected, ovf=1, head popped, sc=15, cnt=16.
- Mid-operation reset: 5 words held, pulse rst asynchronously between edges -> vld, cnt and ovf go to 0 immediately; the next written word 32'h0000_BEEF is the first y seen, after 2 cycles.
